stage_multiple: RTL and testbench

STAGE_MULTIPLE -- requirements
Module: stage_multiple

---
 rtl/stage_multiple.sv | 109 ++++++++++
 tb/tb_stage_multiple.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stage_multiple.sv
// Load/store-multiple sequencer: walks a 16-bit register list, one transfer per cycle, lowest register first.
// Define MULTIPLE_DESCENDING_EN to honour the descending (decrement-before) input; otherwise addressing is increment-after.
module stage_multiple (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        descending,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        w_mem_en_from_multiple,
  output logic        w_reg_en_from_multiple,
  output logic [3:0]  addr_i,
  output logic [31:0] addr_dm_out,
  output logic [31:0] bit_count_number,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] list_q;
  logic        load_q;
  logic [31:0] addr_q;
  logic [3:0]  last_i;
  logic [31:0] last_addr;

  logic [4:0]  count;
  logic        desc_eff;
  logic [31:0] start_addr;
  logic [3:0]  low_idx;
  logic [15:0] list_rest;

`ifdef MULTIPLE_DESCENDING_EN
  assign desc_eff = descending;
`else
  logic unused_descending;
  assign unused_descending = descending;
  assign desc_eff          = 1'b0;
`endif

  always_comb begin
    count = '0;
    for (int k = 0; k < 16; k++) count = count + 5'(reg_list[k]);
  end

  // Scan from the top so the lowest set bit is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int k = 15; k >= 0; k--) if (list_q[k]) low_idx = 4'(k);
  end

  assign list_rest  = list_q & (list_q - 16'd1);
  assign start_addr = desc_eff ? base_addr - {25'd0, count, 2'b00} : base_addr;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = (reg_list != 16'd0) ? XFER : DONE;
      XFER: if (list_rest == 16'd0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q           <= '0;
      load_q           <= 1'b0;
      addr_q           <= '0;
      last_i           <= '0;
      last_addr        <= '0;
      bit_count_number <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          list_q           <= reg_list;
          load_q           <= is_load;
          addr_q           <= start_addr;
          bit_count_number <= {25'd0, count, 2'b00};
        end
        XFER: begin
          list_q    <= list_rest;
          addr_q    <= addr_q + 32'd4;
          last_i    <= low_idx;
          last_addr <= addr_q;
        end
        default: ;
      endcase
    end
  end

  // Outside XFER the index/address outputs show the last transfer made.
  assign busy                   = (state != IDLE);
  assign done                   = (state == DONE);
  assign w_reg_en_from_multiple = (state == XFER) &&  load_q;
  assign w_mem_en_from_multiple = (state == XFER) && !load_q;
  assign addr_i                 = (state == XFER) ? low_idx : last_i;
  assign addr_dm_out            = (state == XFER) ? addr_q  : last_addr;

endmodule

// File: tb/tb_stage_multiple.sv
// Scoreboard bench for stage_multiple: expected transfers are queued when a sequence is launched and popped per XFER cycle.
module tb_stage_multiple;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_load;
  logic        descending;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        busy;
  logic        w_mem_en_from_multiple;
  logic        w_reg_en_from_multiple;
  logic [3:0]  addr_i;
  logic [31:0] addr_dm_out;
  logic [31:0] bit_count_number;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        load;
    logic [3:0]  idx;
    logic [31:0] addr;
  } xfer_t;

  xfer_t sb[$];

  stage_multiple dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .is_load                (is_load),
    .descending             (descending),
    .reg_list               (reg_list),
    .base_addr              (base_addr),
    .busy                   (busy),
    .w_mem_en_from_multiple (w_mem_en_from_multiple),
    .w_reg_en_from_multiple (w_reg_en_from_multiple),
    .addr_i                 (addr_i),
    .addr_dm_out            (addr_dm_out),
    .bit_count_number       (bit_count_number),
    .done                   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"},  32'(busy), 0);
    check({tag, ":done"},  32'(done), 0);
    check({tag, ":strb"},  32'({w_mem_en_from_multiple, w_reg_en_from_multiple}), 0);
    check({tag, ":addri"}, 32'(addr_i), 0);
    check({tag, ":addr"},  addr_dm_out, 0);
    check({tag, ":bcnt"},  bit_count_number, 0);
  endtask

  // Launch one sequence, then walk it cycle by cycle against the queued expectations.
  task automatic run_seq(input string name, input logic ld, input logic desc,
                         input logic [15:0] list, input logic [31:0] base, input logic hold);
    int          n;
    logic [31:0] a;
    xfer_t       e;
    xfer_t       last;
    n    = $countones(list);
    last = '0;
`ifdef MULTIPLE_DESCENDING_EN
    a = desc ? base - 32'(4 * n) : base;
`else
    a = base;
`endif
    for (int k = 0; k < 16; k++) begin
      if (list[k]) begin
        sb.push_back('{load: ld, idx: 4'(k), addr: a});
        a = a + 32'd4;
      end
    end

    @(negedge clk);
    start = 1'b1; is_load = ld; descending = desc; reg_list = list; base_addr = base;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    // Disturb the inputs: the sequence must run on latched values only.
    is_load = ~ld; reg_list = ~list; base_addr = 32'hDEAD_BEEF; descending = ~desc;

    while (sb.size() > 0) begin
      e    = sb.pop_front();
      last = e;
      check({name, ":wreg"},  32'(w_reg_en_from_multiple), 32'(e.load));
      check({name, ":wmem"},  32'(w_mem_en_from_multiple), 32'(!e.load));
      check({name, ":addri"}, 32'(addr_i), 32'(e.idx));
      check({name, ":addr"},  addr_dm_out, e.addr);
      check({name, ":busy"},  32'(busy), 1);
      check({name, ":done0"}, 32'(done), 0);
      check({name, ":bcnt"},  bit_count_number, 32'(4 * n));
      @(posedge clk); #1;
    end

    check({name, ":done"},   32'(done), 1);
    check({name, ":dbusy"},  32'(busy), 1);
    check({name, ":dstrb"},  32'({w_mem_en_from_multiple, w_reg_en_from_multiple}), 0);
    @(posedge clk); #1;
    check({name, ":idone"},  32'(done), 0);
    check({name, ":ibusy"},  32'(busy), 0);
    check({name, ":istrb"},  32'({w_mem_en_from_multiple, w_reg_en_from_multiple}), 0);
    check({name, ":ibcnt"},  bit_count_number, 32'(4 * n));
    if (n > 0) begin
      check({name, ":iaddri"}, 32'(addr_i), 32'(last.idx));
      check({name, ":iaddr"},  addr_dm_out, last.addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; descending = 1'b0;
    reg_list = '0; base_addr = '0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;

    run_seq("stm",   1'b0, 1'b0, 16'h0013, 32'h0000_0100, 1'b0);
    run_seq("pop",   1'b1, 1'b0, 16'h8001, 32'h0000_0200, 1'b0);
    run_seq("push",  1'b0, 1'b1, 16'h40F0, 32'h0000_1000, 1'b0);
    run_seq("wrap",  1'b0, 1'b1, 16'h0003, 32'h0000_0004, 1'b0);
    run_seq("empty", 1'b0, 1'b0, 16'h0000, 32'h0000_0500, 1'b0);
    run_seq("full",  1'b1, 1'b0, 16'hFFFF, 32'hFFFF_FFF0, 1'b0);

    // Held start: second sequence only begins on the first IDLE edge.
    run_seq("hold1", 1'b1, 1'b0, 16'h0006, 32'h0000_0400, 1'b1);
    run_seq("hold2", 1'b0, 1'b0, 16'h0006, 32'h0000_0600, 1'b0);

    // Reset in the second XFER cycle of an 8-register list.
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; descending = 1'b0; reg_list = 16'h00FF; base_addr = 32'h0000_0300;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort:x1addr", addr_dm_out, 32'h0000_0300);
    @(posedge clk); #1;
    check("abort:x2addri", 32'(addr_i), 1);
    check("abort:x2wmem",  32'(w_mem_en_from_multiple), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    check_reset_outputs("abort_hold");
    @(negedge clk); rst_n = 1'b1;

    run_seq("after", 1'b0, 1'b0, 16'h0013, 32'h0000_0100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
